// File: rtl/sort_burst_writer.sv
// sort_burst_writer
//   Collects sorted lines from the merger into a single MB-entry line buffer
//   and writes them to DRAM as Avalon-MM write bursts of up to MB lines.
//   Jobs are started with a one-cycle start pulse that latches a byte base
//   address and a line count. The buffer is filled, then emptied as one burst,
//   then refilled, until every line has been written.
//
// Optional feature (macro SORT_WRITER_ACKWAIT_EN):
//   defined   - after the last beat the block waits until one dst_writeack has
//               been counted per line before pulsing done.
//   undefined - done follows the last beat directly; dst_writeack is unused.
//
// Ports
//   clock, resetn             clock, asynchronous active-low reset
//   start/base_addr/numlines  job request (honoured only when idle)
//   din/din_valid/din_ready   line stream from the merger
//   dst_*                     Avalon-MM burst write master
//   busy                      job in progress
//   done                      one-cycle pulse when the job completes
module sort_burst_writer #(
  parameter int MAXBURST_LOG   = 4,
  parameter int DRAM_ADDRSPACE = 64,
  parameter int DRAM_DATAWIDTH = 512,
  parameter int NUMW           = 32
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [DRAM_ADDRSPACE-1:0]   base_addr,
  input  logic [NUMW-1:0]             numlines,
  input  logic [DRAM_DATAWIDTH-1:0]   din,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic [DRAM_ADDRSPACE-1:0]   dst_address,
  output logic                        dst_write,
  output logic [DRAM_DATAWIDTH-1:0]   dst_writedata,
  output logic [DRAM_DATAWIDTH/8-1:0] dst_byteenable,
  output logic [MAXBURST_LOG:0]       dst_burstcount,
  output logic                        dst_read,
  input  logic                        dst_waitrequest,
  input  logic                        dst_writeack,
  output logic                        busy,
  output logic                        done
);

  localparam int MB         = 1 << MAXBURST_LOG;
  localparam int LINE_BYTES = DRAM_DATAWIDTH / 8;
  localparam int CW         = MAXBURST_LOG + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_BURST,
    S_DRAIN,
    S_DONE
  } state_t;

  // Progress of the running job: next burst address and lines still unwritten.
  typedef struct packed {
    logic [DRAM_ADDRSPACE-1:0] addr;
    logic [NUMW-1:0]           remaining;
  } job_t;

  state_t                    state, state_nx;
  job_t                      job;
  logic [CW-1:0]             fill_cnt;    // lines held in the buffer
  logic [CW-1:0]             beat_idx;    // next buffer entry to send
  logic [CW-1:0]             burst_len;   // length of the burst in flight, 0 outside BURST
  logic [CW-1:0]             target;
  logic [DRAM_ADDRSPACE-1:0] addr_step;
  logic                      din_fire, beat_fire, last_beat, drain_exit;
  logic [DRAM_DATAWIDTH-1:0] line_buf [MB];

  // Lines to gather before the next burst: a full burst, or the tail.
  assign target    = (job.remaining < NUMW'(MB)) ? job.remaining[CW-1:0] : CW'(MB);
  assign din_fire  = din_ready && din_valid;
  assign beat_fire = dst_write && !dst_waitrequest;
  assign last_beat = beat_fire && (beat_idx == burst_len - CW'(1));
  assign addr_step = DRAM_ADDRSPACE'(burst_len) * DRAM_ADDRSPACE'(LINE_BYTES);

  assign dst_address    = job.addr;
  assign dst_burstcount = burst_len;
  assign dst_writedata  = line_buf[beat_idx[MAXBURST_LOG-1:0]];
  assign dst_byteenable = '1;
  assign dst_read       = 1'b0;

`ifdef SORT_WRITER_ACKWAIT_EN
  logic [NUMW-1:0] ack_cnt;
  logic [NUMW-1:0] numlines_q;

  // Acks are only meaningful inside a job; the count restarts while idle so
  // stray acks from an aborted or finished job never leak into the next one.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ack_cnt    <= '0;
      numlines_q <= '0;
    end else if (state == S_IDLE) begin
      ack_cnt <= '0;
      if (start) numlines_q <= numlines;
    end else if (dst_writeack) begin
      ack_cnt <= ack_cnt + NUMW'(1);
    end
  end

  assign drain_exit = (ack_cnt == numlines_q);
`else
  logic unused_writeack;
  assign unused_writeack = dst_writeack;
  assign drain_exit      = 1'b1;
`endif

  // Next state and handshake outputs.
  always_comb begin
    state_nx  = state;
    din_ready = 1'b0;
    dst_write = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = (numlines == '0) ? S_DONE : S_FILL;
      end
      S_FILL: begin
        busy = 1'b1;
        if (fill_cnt == target) state_nx = S_BURST;
        else                    din_ready = 1'b1;
      end
      S_BURST: begin
        busy      = 1'b1;
        dst_write = 1'b1;
        // burst_len never exceeds remaining, so equality means nothing is left.
        if (last_beat)
          state_nx = (job.remaining == NUMW'(burst_len)) ? S_DRAIN : S_FILL;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_exit) state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      job       <= '0;
      fill_cnt  <= '0;
      beat_idx  <= '0;
      burst_len <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            job.addr      <= base_addr;
            job.remaining <= numlines;
          end
        end
        S_FILL: begin
          if (din_fire) fill_cnt <= fill_cnt + CW'(1);
          // Burst geometry is frozen here and held for every beat and stall.
          if (state_nx == S_BURST) burst_len <= target;
        end
        S_BURST: begin
          if (last_beat) begin
            beat_idx      <= '0;
            fill_cnt      <= '0;
            burst_len     <= '0;
            job.addr      <= job.addr + addr_step;
            job.remaining <= job.remaining - NUMW'(burst_len);
          end else if (beat_fire) begin
            beat_idx <= beat_idx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset: entries are always written before being read.
  always_ff @(posedge clock) begin
    if (din_fire) line_buf[fill_cnt[MAXBURST_LOG-1:0]] <= din;
  end

endmodule
